// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared encodings and FSM states for the UART path
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam int OVERSAMPLE_DEFAULT = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

endpackage

// File: rtl/uart_tx_holdreg.sv
// rtl/uart_tx_holdreg.sv - one-entry valid/ready holding register feeding the UART shifter
module uart_tx_holdreg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              drain,
  output logic              ready,
  output logic              full,
  output logic [DATA_W-1:0] data
);

  // drain only happens while full, and ready is low while full, so the two never collide
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full <= 1'b0;
      data <= '0;
    end else if (load_valid && ready) begin
      full <= 1'b1;
      data <= load_data;
    end else if (drain) begin
      full <= 1'b0;
    end
  end

  assign ready = !full;

endmodule

// File: rtl/uart_tx_framed.sv
// rtl/uart_tx_framed.sv - framed UART transmitter: start, LSB-first data, optional parity, 1/2 stop bits
module uart_tx_framed
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int PARITY     = PAR_NONE,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              tx
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_W);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
    $error("uart_tx_framed: DATA_W must be in 5..9");
  end
  if (PARITY != PAR_NONE && PARITY != PAR_EVEN && PARITY != PAR_ODD) begin : g_bad_parity
    $error("uart_tx_framed: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_framed: STOP_BITS must be 1 or 2");
  end
  if (OVERSAMPLE < 2) begin : g_bad_os
    $error("uart_tx_framed: OVERSAMPLE must be >= 2");
  end

  tx_state_t         state, state_nxt;
  logic [DATA_W-1:0] shifter, shift_nxt;
  logic [TW-1:0]     tick_cnt, tick_nxt;
  logic [BW-1:0]     bit_cnt, bit_nxt;
  logic              stop_cnt, stop_nxt;
  logic              par_bit, par_nxt;
  logic              tx_nxt, done_nxt;
  logic              bit_end, drain;
  logic              buf_full;
  logic [DATA_W-1:0] buf_data;

  uart_tx_holdreg #(.DATA_W(DATA_W)) u_hold (
    .clk        (clk),
    .reset      (reset),
    .load_valid (tx_valid),
    .load_data  (tx_data),
    .drain      (drain),
    .ready      (tx_ready),
    .full       (buf_full),
    .data       (buf_data)
  );

  assign bit_end = tick && (tick_cnt == TICK_LAST);
  assign tx_busy = (state != ST_IDLE);

  always_comb begin
    state_nxt = state;
    shift_nxt = shifter;
    tick_nxt  = tick_cnt;
    bit_nxt   = bit_cnt;
    stop_nxt  = stop_cnt;
    par_nxt   = par_bit;
    done_nxt  = 1'b0;
    drain     = 1'b0;
    tx_nxt    = 1'b1;

    if (state != ST_IDLE && tick) begin
      tick_nxt = bit_end ? '0 : tick_cnt + 1'b1;
    end

    case (state)
      ST_START: if (bit_end) state_nxt = ST_DATA;
      ST_DATA: begin
        if (bit_end) begin
          shift_nxt = shifter >> 1;
          if (bit_cnt == BIT_LAST) begin
            bit_nxt   = '0;
            state_nxt = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_nxt = bit_cnt + 1'b1;
          end
        end
      end
      ST_PARITY: if (bit_end) state_nxt = ST_STOP;
      ST_STOP: begin
        if (bit_end) begin
          if (stop_cnt == STOP_LAST) begin
            stop_nxt  = 1'b0;
            done_nxt  = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            stop_nxt = stop_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // A waiting word starts a frame whenever the line would otherwise go idle,
    // which covers both the idle case and back-to-back frames off the last stop tick.
    if (buf_full && state_nxt == ST_IDLE) begin
      state_nxt = ST_START;
      drain     = 1'b1;
      shift_nxt = buf_data;
      par_nxt   = (^buf_data) ^ (PARITY == PAR_ODD);
      tick_nxt  = '0;
      bit_nxt   = '0;
      stop_nxt  = 1'b0;
    end

    case (state_nxt)
      ST_START:  tx_nxt = 1'b0;
      ST_DATA:   tx_nxt = shift_nxt[0];
      ST_PARITY: tx_nxt = par_nxt;
      default:   tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      shifter  <= '0;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      par_bit  <= 1'b0;
      tx       <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_nxt;
      shifter  <= shift_nxt;
      tick_cnt <= tick_nxt;
      bit_cnt  <= bit_nxt;
      stop_cnt <= stop_nxt;
      par_bit  <= par_nxt;
      tx       <= tx_nxt;
      tx_done  <= done_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_framed.sv
// tb/tb_uart_tx_framed.sv - scoreboard bench for uart_tx_framed across parity/stop/width variants
module tb_uart_tx_framed;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       tx_valid = 1'b0;
  logic [8:0] tx_data = '0;
  logic [3:0] valid_w, ready_w, busy_w, done_w, tx_w;
  int         sel = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  int         done_cnt = 0;
  logic       last_done_tx = 1'b1;
  logic       exp_q[$];

  int dw_a[4] = '{8, 8, 8, 9};
  int par_a[4] = '{PAR_NONE, PAR_EVEN, PAR_ODD, PAR_NONE};
  int sb_a[4] = '{1, 1, 1, 2};

  always #5 clk = ~clk;

  assign valid_w = tx_valid ? 4'(1 << sel) : 4'b0;

  uart_tx_framed u0 (
    .clk(clk), .reset(reset), .tick(tick), .tx_valid(valid_w[0]), .tx_data(tx_data[7:0]),
    .tx_ready(ready_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]), .tx(tx_w[0]));
  uart_tx_framed #(.PARITY(PAR_EVEN)) u1 (
    .clk(clk), .reset(reset), .tick(tick), .tx_valid(valid_w[1]), .tx_data(tx_data[7:0]),
    .tx_ready(ready_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]), .tx(tx_w[1]));
  uart_tx_framed #(.PARITY(PAR_ODD)) u2 (
    .clk(clk), .reset(reset), .tick(tick), .tx_valid(valid_w[2]), .tx_data(tx_data[7:0]),
    .tx_ready(ready_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]), .tx(tx_w[2]));
  uart_tx_framed #(.DATA_W(9), .STOP_BITS(2)) u3 (
    .clk(clk), .reset(reset), .tick(tick), .tx_valid(valid_w[3]), .tx_data(tx_data),
    .tx_ready(ready_w[3]), .tx_busy(busy_w[3]), .tx_done(done_w[3]), .tx(tx_w[3]));

  // one tick every 4 clocks, changed just after the rising edge
  initial begin
    int c;
    c = 0;
    forever begin
      @(posedge clk);
      #1;
      tick = (c == 3);
      c = (c + 1) % 4;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int frame_len(input int idx);
    return 1 + dw_a[idx] + ((par_a[idx] != PAR_NONE) ? 1 : 0) + sb_a[idx];
  endfunction

  task automatic push_frame(input int data, input int idx);
    logic p;
    p = 1'b0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < dw_a[idx]; i++) begin
      exp_q.push_back(data[i]);
      p ^= data[i];
    end
    if (par_a[idx] == PAR_EVEN) exp_q.push_back(p);
    if (par_a[idx] == PAR_ODD)  exp_q.push_back(!p);
    for (int i = 0; i < sb_a[idx]; i++) exp_q.push_back(1'b1);
  endtask

  task automatic send(input int data, input int idx);
    int w;
    w = 0;
    @(negedge clk);
    while (!ready_w[sel] && w < 2000) begin
      @(negedge clk);
      w++;
    end
    check_eq("ready_before_send", ready_w[sel], 1);
    tx_data  = 9'(data);
    tx_valid = 1'b1;
    push_frame(data, idx);
    @(posedge clk);
    #1 tx_valid = 1'b0;
    check_eq("ready_after_accept", ready_w[sel], 0);
  endtask

  task automatic wait_idle(input string tag);
    int w;
    w = 0;
    @(negedge clk);
    while ((busy_w[sel] || !ready_w[sel]) && w < 5000) begin
      @(negedge clk);
      w++;
    end
    check_eq({tag, "_idle"}, busy_w[sel], 0);
    repeat (3) @(negedge clk);
    check_eq({tag, "_queue_empty"}, exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (done_w[sel]) begin
      done_cnt     <= done_cnt + 1;
      last_done_tx <= tx_w[sel];
    end
  end

  // frame monitor: counts ticks from the start-bit fall and samples each bit mid-period
  initial begin
    logic prev, aborted, b;
    int   cnt;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      while (!reset && !tx_w[sel] && prev) begin
        cnt = 0;
        aborted = 1'b0;
        for (int c = 0; c < 4000; c++) begin
          if (reset) begin
            aborted = 1'b1;
            break;
          end
          if (c > 0 && done_w[sel]) break;
          if (tick) begin
            cnt++;
            if (cnt % 16 == 8) begin
              b = (exp_q.size() > 0) ? exp_q.pop_front() : !tx_w[sel];
              check_eq("serial_bit", tx_w[sel], b);
            end
          end
          @(negedge clk);
        end
        if (!aborted) check_eq("frame_ticks", cnt, frame_len(sel) * 16);
        prev = 1'b1;
      end
      prev = tx_w[sel];
    end
  end

  initial begin
    int d0, w;
    logic stayed;

    repeat (3) @(negedge clk);
    check_eq("reset_tx", tx_w, 4'hF);
    check_eq("reset_ready", ready_w, 4'hF);
    check_eq("reset_busy", busy_w, 4'h0);
    check_eq("reset_done", done_w, 4'h0);
    @(posedge clk);
    #1 reset = 1'b0;

    sel = 0; d0 = done_cnt;
    send(8'hA5, 0);
    wait_idle("t1");
    check_eq("t1_done_count", done_cnt - d0, 1);

    sel = 1; d0 = done_cnt;
    send(8'h07, 1);
    wait_idle("t2_even");
    check_eq("t2_even_done_count", done_cnt - d0, 1);

    sel = 2; d0 = done_cnt;
    send(8'h07, 2);
    wait_idle("t2_odd");
    check_eq("t2_odd_done_count", done_cnt - d0, 1);

    sel = 0; d0 = done_cnt;
    send(8'h55, 0);
    send(8'hAA, 0);
    w = 0;
    while (done_cnt - d0 < 1 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    check_eq("t3_second_start_on_done", last_done_tx, 0);
    wait_idle("t3");
    check_eq("t3_done_count", done_cnt - d0, 2);

    sel = 3; d0 = done_cnt;
    send(9'h1FF, 3);
    wait_idle("t4");
    check_eq("t4_done_count", done_cnt - d0, 1);

    sel = 0; d0 = done_cnt;
    send(8'hA5, 0);
    repeat (290) @(negedge clk);
    check_eq("t5_bit3_low", tx_w[0], 0);
    #1 reset = 1'b1;
    #1;
    check_eq("t5_reset_tx", tx_w[0], 1);
    check_eq("t5_reset_ready", ready_w[0], 1);
    check_eq("t5_reset_busy", busy_w[0], 0);
    @(negedge clk);
    @(negedge clk);
    check_eq("t5_no_done", done_cnt - d0, 0);
    exp_q.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    d0 = done_cnt;
    send(8'h3C, 0);
    wait_idle("t5_after");
    check_eq("t5_after_done_count", done_cnt - d0, 1);

    sel = 0; d0 = done_cnt; stayed = 1'b1;
    repeat (200) begin
      @(negedge clk);
      if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) stayed = 1'b0;
    end
    check_eq("t6_idle_line", stayed, 1);
    check_eq("t6_tick_cnt", u0.tick_cnt, 0);
    check_eq("t6_bit_cnt", u0.bit_cnt, 0);
    check_eq("t6_no_done", done_cnt - d0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
